// File: rtl/ring_sequence_monitor_if.sv
// Status/sample bundle between the ring counter, the sequence monitor and its consumers.
// The monitor drives the status side; the producer drives the sample side.
interface ring_sequence_monitor_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] ring_in;
  logic             ring_valid;
  logic             clear_stats;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             locked;
  logic             err_pulse;
  logic             sticky_err;
  logic [ERR_W-1:0] err_cnt;
  logic             rev_pulse;
  logic [REV_W-1:0] rev_cnt;

  modport master (
    output ring_in, ring_valid, clear_stats,
    input  index, index_valid, locked, err_pulse, sticky_err, err_cnt, rev_pulse, rev_cnt
  );

  modport slave (
    input  ring_in, ring_valid, clear_stats,
    output index, index_valid, locked, err_pulse, sticky_err, err_cnt, rev_pulse, rev_cnt
  );
endinterface

// File: rtl/ring_sequence_monitor.sv
// Checks a one-hot ring counter stream: legality, single-step advance, lock detection,
// and revolution/error statistics. All status outputs are registered.
module ring_sequence_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned REV_W      = 8,
  parameter int unsigned ERR_W      = 8
) (
  input logic                     clk,
  input logic                     rst,
  ring_sequence_monitor_if.slave  mon_if
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MCW   = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [MCW-1:0]   match_q, match_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             rev_pulse_q, rev_pulse_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

  logic [CNT_W-1:0] ones_c;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] exp_idx_c;
  logic             legal_c;
  logic             step_ok_c;
  logic             wrap_c;

  // One-hot decode: population count and position of the set bit
  always_comb begin
    ones_c = '0;
    idx_c  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (mon_if.ring_in[i]) begin
        ones_c = ones_c + CNT_W'(1);
        idx_c  = IDX_W'(i);
      end
    end
  end

  // index_q doubles as the previous legal position
  assign legal_c   = (ones_c == CNT_W'(1));
  assign wrap_c    = (index_q == IDX_W'(WIDTH - 1));
  assign exp_idx_c = wrap_c ? '0 : index_q + IDX_W'(1);
  assign step_ok_c = legal_c && (idx_c == exp_idx_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (mon_if.ring_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal_c) begin
            state_d = TRACK;
            match_d = MCW'(1);
          end
        end
        TRACK: begin
          if (step_ok_c) begin
            match_d = match_q + MCW'(1);
            if (match_d >= MCW'(LOCK_COUNT)) state_d = LOCKED;
          end else if (legal_c) begin
            match_d = MCW'(1);
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (!step_ok_c) begin
            state_d = legal_c ? TRACK : HUNT;
            match_d = MCW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Status next-values; a statistics clear overrides any same-cycle increment
  always_comb begin
    index_d       = index_q;
    index_valid_d = index_valid_q;
    locked_d      = (state_d == LOCKED);
    err_pulse_d   = 1'b0;
    rev_pulse_d   = 1'b0;
    sticky_d      = sticky_q;
    err_cnt_d     = err_cnt_q;
    rev_cnt_d     = rev_cnt_q;
    if (mon_if.ring_valid) begin
      index_valid_d = legal_c;
      if (legal_c) index_d = idx_c;
      if (state_q == LOCKED) begin
        err_pulse_d = !step_ok_c;
        rev_pulse_d = step_ok_c && wrap_c;
      end
    end
    if (err_pulse_d) begin
      sticky_d = 1'b1;
      if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
    if (rev_pulse_d) rev_cnt_d = rev_cnt_q + REV_W'(1);
    if (mon_if.clear_stats) begin
      sticky_d  = 1'b0;
      err_cnt_d = '0;
      rev_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      sticky_q      <= 1'b0;
      err_cnt_q     <= '0;
      rev_pulse_q   <= 1'b0;
      rev_cnt_q     <= '0;
    end else begin
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      sticky_q      <= sticky_d;
      err_cnt_q     <= err_cnt_d;
      rev_pulse_q   <= rev_pulse_d;
      rev_cnt_q     <= rev_cnt_d;
    end
  end

  assign mon_if.index       = index_q;
  assign mon_if.index_valid = index_valid_q;
  assign mon_if.locked      = locked_q;
  assign mon_if.err_pulse   = err_pulse_q;
  assign mon_if.sticky_err  = sticky_q;
  assign mon_if.err_cnt     = err_cnt_q;
  assign mon_if.rev_pulse   = rev_pulse_q;
  assign mon_if.rev_cnt     = rev_cnt_q;
endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: vector table + scoreboard, two instances (8-bit and
// 2-bit error counters) fed the same stream, plus async-reset corner sequences.
module tb_ring_sequence_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ring;
  logic       vld;
  logic       clr;

  always #5 clk = ~clk;

  ring_sequence_monitor_if #(.WIDTH(4), .REV_W(8), .ERR_W(8)) mon_if ();
  ring_sequence_monitor_if #(.WIDTH(4), .REV_W(8), .ERR_W(2)) sat_if ();

  assign mon_if.ring_in     = ring;
  assign mon_if.ring_valid  = vld;
  assign mon_if.clear_stats = clr;
  assign sat_if.ring_in     = ring;
  assign sat_if.ring_valid  = vld;
  assign sat_if.clear_stats = clr;

  ring_sequence_monitor #(.WIDTH(4), .LOCK_COUNT(4), .REV_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .mon_if(mon_if.slave));
  ring_sequence_monitor #(.WIDTH(4), .LOCK_COUNT(4), .REV_W(8), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mon_if(sat_if.slave));

  typedef struct {
    logic [3:0] ring;
    logic       vld;
    logic       clr;
    int         gap;
    int         idx;
    logic       iv, lk, ep, rp;
  } vec_t;

  typedef struct {
    int   row;
    int   idx;
    logic iv, lk, ep, rp, sticky;
    int   err, errs, rev;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Counter/status model driven by the expected pulses
  int   m_idx, m_err, m_errs, m_rev;
  logic m_iv, m_lk, m_sticky;

  function automatic void chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, act, exp);
    end
  endfunction

  function automatic void add(logic [3:0] r, logic v, logic c, int g, int ix,
                              logic iv, logic lk, logic ep, logic rp);
    vec_t t;
    t = '{ring: r, vld: v, clr: c, gap: g, idx: ix, iv: iv, lk: lk, ep: ep, rp: rp};
    tbl.push_back(t);
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_err = 0; m_errs = 0; m_rev = 0;
    m_iv = 1'b0; m_lk = 1'b0; m_sticky = 1'b0;
  endfunction

  function automatic void push_exp(int row, logic ep, logic rp);
    exp_t e;
    e = '{row: row, idx: m_idx, iv: m_iv, lk: m_lk, ep: ep, rp: rp, sticky: m_sticky,
          err: m_err, errs: m_errs, rev: m_rev};
    sb.push_back(e);
  endfunction

  task automatic apply(vec_t v, int row);
    @(negedge clk);
    ring = v.ring; vld = v.vld; clr = v.clr;
    m_idx = v.idx; m_iv = v.iv; m_lk = v.lk;
    if (v.ep) begin
      m_sticky = 1'b1;
      if (m_err < 255) m_err++;
      if (m_errs < 3) m_errs++;
    end
    if (v.rp) m_rev = (m_rev + 1) % 256;
    if (v.clr) begin
      m_sticky = 1'b0; m_err = 0; m_errs = 0; m_rev = 0;
    end
    push_exp(row, v.ep, v.rp);
    for (int g = 0; g < v.gap; g++) begin
      @(negedge clk);
      ring = 4'b1111; vld = 1'b0; clr = 1'b0;
      push_exp(row, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    vld = 1'b0; clr = 1'b0; ring = 4'b0000;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", -1, sb.size(), 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_index"},  -1, mon_if.index, 0);
    chk({tag, "_ivalid"}, -1, mon_if.index_valid, 0);
    chk({tag, "_locked"}, -1, mon_if.locked, 0);
    chk({tag, "_errp"},   -1, mon_if.err_pulse, 0);
    chk({tag, "_sticky"}, -1, mon_if.sticky_err, 0);
    chk({tag, "_errcnt"}, -1, mon_if.err_cnt, 0);
    chk({tag, "_revp"},   -1, mon_if.rev_pulse, 0);
    chk({tag, "_revcnt"}, -1, mon_if.rev_cnt, 0);
    chk({tag, "_sat_errcnt"}, -1, sat_if.err_cnt, 0);
    chk({tag, "_sat_locked"}, -1, sat_if.locked, 0);
  endtask

  // Scoreboard consumer: one expected record per clock, checked after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("index",       e.row, mon_if.index, e.idx);
      chk("index_valid", e.row, mon_if.index_valid, e.iv);
      chk("locked",      e.row, mon_if.locked, e.lk);
      chk("err_pulse",   e.row, mon_if.err_pulse, e.ep);
      chk("rev_pulse",   e.row, mon_if.rev_pulse, e.rp);
      chk("sticky_err",  e.row, mon_if.sticky_err, e.sticky);
      chk("err_cnt",     e.row, mon_if.err_cnt, e.err);
      chk("rev_cnt",     e.row, mon_if.rev_cnt, e.rev);
      chk("sat_err_cnt", e.row, sat_if.err_cnt, e.errs);
      chk("sat_sticky",  e.row, sat_if.sticky_err, e.sticky);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   ring     vld   clr  gap idx iv  lk  ep  rp
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0);   // 0  rotation into lock
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 1, 0, 1);   // 4  first wrap
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 1, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 1, 0, 0);   // 6  skip error follows
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 1, 0);
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);   // 10 relocked, sticky held
    add(4'b0000, 1'b1, 1'b0, 0, 3, 0, 0, 1, 0);   // 11 zero pattern while locked
    add(4'b0011, 1'b1, 1'b0, 0, 3, 0, 0, 0, 0);   // 12 multi-hot in HUNT: no error
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0);
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);
    add(4'b0001, 1'b1, 1'b0, 5, 0, 1, 1, 0, 1);   // 17 strobe gaps
    add(4'b0010, 1'b1, 1'b0, 5, 1, 1, 1, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 5, 2, 1, 1, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 5, 3, 1, 1, 0, 0);
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 1, 0, 1);
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 1, 0);   // 22 repeat error
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 1, 0);   // 26 4th error
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 0, 0, 0);
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0);
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 1, 0, 0);
    add(4'b1100, 1'b1, 1'b0, 0, 1, 0, 0, 1, 0);   // 30 5th error, 2-bit count saturated
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0);
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 0, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);
    add(4'b1000, 1'b1, 1'b1, 0, 3, 1, 0, 1, 0);   // 35 6th error with clear
    add(4'b0001, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0);
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
    add(4'b0100, 1'b1, 1'b0, 0, 2, 1, 1, 0, 0);
    add(4'b1000, 1'b1, 1'b0, 0, 3, 1, 1, 0, 0);
    add(4'b0001, 1'b1, 1'b1, 0, 0, 1, 1, 0, 1);   // 40 wrap with clear
    add(4'b0010, 1'b1, 1'b0, 0, 1, 1, 1, 0, 0);

    ring = 4'b0000; vld = 1'b0; clr = 1'b0; rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    drain();
    chk("locked_before_async_rst", -1, mon_if.locked, 1);

    // Async reset between edges must clear outputs without a clock edge
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    apply('{ring: 4'b0100, vld: 1'b1, clr: 1'b0, gap: 0, idx: 2, iv: 1'b1, lk: 1'b0, ep: 1'b0, rp: 1'b0}, 100);
    apply('{ring: 4'b1000, vld: 1'b1, clr: 1'b0, gap: 0, idx: 3, iv: 1'b1, lk: 1'b0, ep: 1'b0, rp: 1'b0}, 101);
    apply('{ring: 4'b0001, vld: 1'b1, clr: 1'b0, gap: 0, idx: 0, iv: 1'b1, lk: 1'b0, ep: 1'b0, rp: 1'b0}, 102);
    apply('{ring: 4'b0010, vld: 1'b1, clr: 1'b0, gap: 0, idx: 1, iv: 1'b1, lk: 1'b1, ep: 1'b0, rp: 1'b0}, 103);
    apply('{ring: 4'b0100, vld: 1'b1, clr: 1'b0, gap: 0, idx: 2, iv: 1'b1, lk: 1'b1, ep: 1'b0, rp: 1'b0}, 104);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_sequence_monitor.md
Name: ring_sequence_monitor

Overview:
- Sits directly downstream of the 4-bit ring counter and consumes its one-hot output.
- Checks that the pattern is a legal one-hot value and advances by exactly one position per sample strobe.
- Encodes the one-hot value to a binary index, declares lock after consecutive good steps, and counts revolutions and sequence errors.
- Drives status outputs consumed by display and debug logic.

Parameters:
WIDTH, 4, ring length in bits (≥2)
LOCK_COUNT, 4, consecutive legal one-hot samples required to reach LOCKED (≥2)
REV_W, 8, revolution counter width
ERR_W, 8, error counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ring_in  input  WIDTH  one-hot pattern from ring counter
ring_valid  input  1  sample strobe; ring_in evaluated only when high
clear_stats  input  1  synchronous clear of rev_cnt, err_cnt, sticky_err
index  output  $clog2(WIDTH)  binary position of set bit in last legal sample
index_valid  output  1  last sample was legal one-hot
locked  output  1  high in LOCKED state
err_pulse  output  1  one-cycle pulse on sequence error in LOCKED
sticky_err  output  1  set by any err_pulse; cleared only by rst/clear_stats
err_cnt  output  ERR_W  saturating error count
rev_pulse  output  1  one-cycle pulse on wrap WIDTH-1 -> 0 while LOCKED
rev_cnt  output  REV_W  wrapping revolution count

Behaviour:
- Interface: one clock, clk; rst asynchronous, active-high. All outputs registered; all cleared to 0 while rst is high. State after reset = HUNT.
- Latency: outputs reflect a sample one cycle after the clk edge where ring_valid=1.
- ring_valid=0: state, index, index_valid, and counters hold; err_pulse and rev_pulse = 0.
- Legal sample: exactly one bit set. idx = bit position. Expected next = (prev_idx+1) mod WIDTH, matching left rotation (0001 -> 0010 -> 0100 -> 1000 -> 0001).
- Illegal sample (zero or multi-hot): index_valid=0, index holds its previous value.
- HUNT:
  - Legal sample: record idx, match_cnt=1, go TRACK.
  - Illegal sample: stay in HUNT.
- TRACK:
  - Legal sample with idx == expected: match_cnt+1. Go LOCKED when match_cnt reaches LOCK_COUNT, so locked rises on the output cycle of the LOCK_COUNT-th legal sample.
  - Legal sample with idx != expected: restart, record idx, match_cnt=1, stay in TRACK.
  - Illegal sample: go HUNT.
  - No errors are flagged in HUNT or TRACK.
- LOCKED:
  - Legal sample with idx == expected: stay in LOCKED. If prev_idx == WIDTH-1 and idx == 0, assert rev_pulse and increment rev_cnt (wraps).
  - Error: any illegal sample, skip, or repeat (idx == prev_idx). Response: err_pulse=1, sticky_err=1, err_cnt+1 saturating at all-ones, locked=0.
  - Next state after an error: TRACK with match_cnt=1 if the erroring sample was legal, else HUNT.
- clear_stats=1:
  - rev_cnt, err_cnt, and sticky_err go to 0 on the next edge. State, index, and locked are unaffected.
  - If it coincides with an error: err_pulse still asserts, counters and sticky end at 0 (clear wins).
  - If it coincides with a wrap: rev_pulse asserts, rev_cnt ends at 0.
- rst mid-operation: immediate return to HUNT with all outputs 0. Re-lock requires LOCK_COUNT fresh legal samples.

Test Plan:
- Reset then rotation:
  - Assert rst; all outputs must be 0.
  - Release rst, ring_valid=1, feed 0001, 0010, 0100, 1000.
  - index must read 0, 1, 2, 3; locked=1 after the 4th sample's edge.
  - Next 0001 gives rev_pulse=1 and rev_cnt=1.
- Skip error:
  - Once locked at 0010, feed 0100 then 0001.
  - Required: err_pulse for one cycle, err_cnt=1, sticky_err=1, locked=0.
  - After 3 more legal steps, locked=1 again and sticky_err stays 1.
- Illegal patterns:
  - While locked, feed 0000: error, state HUNT, index_valid=0, index unchanged.
  - Then feed 0011: no error (in HUNT), err_cnt unchanged.
- Strobe gaps:
  - Locked stream with ring_valid low for 5 cycles between samples.
  - Required: no errors, rev_cnt increments once per 4 valid samples.
- Saturation and clear:
  - With ERR_W=2, force 5 errors: err_cnt must be 3.
  - Assert clear_stats on the cycle of a 6th error: err_pulse=1, err_cnt=0, sticky_err=0.
- Async reset mid-lock:
  - Assert rst between clock edges while locked: outputs must be 0 immediately, without waiting for an edge.
  - After release, 3 legal samples leave locked=0; the 4th sets locked=1.
